ssegment_reader: RTL and testbench

SSEGMENT_READER -- requirements
Module: ssegment_reader

---
 rtl/ssegment_reader_if.sv | 21 ++
 rtl/ssegment_reader.sv | 150 +++++++++++++++
 tb/tb_ssegment_reader.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ssegment_reader_if.sv
// Bundle between a multiplexed seven-segment display driver and its reader.
// The driver side (master) supplies digit selects and segment levels; the
// reader side (slave) returns the decoded digits and per-digit status.
interface ssegment_reader_if;
   logic [3:0]  grounds;   // digit selects, active-low, bit i = digit i
   logic [6:0]  display;   // segments {a,b,c,d,e,f,g}, active-high
   logic [15:0] digits;    // decoded hex value per digit, digit i in [4i+3:4i]
   logic [3:0]  valid;     // digit i last captured a legal pattern
   logic [3:0]  err;       // digit i last captured an illegal pattern
   logic        frame;     // one-cycle pulse when all digits captured

   modport master (
      output grounds, display,
      input  digits, valid, err, frame
   );

   modport slave (
      input  grounds, display,
      output digits, valid, err, frame
   );
endinterface

// File: rtl/ssegment_reader.sv
// Seven-segment display reader: watches a multiplexed display, waits for the
// select/segment pair to dwell for STABLE_CNT matching edges, then decodes
// the pattern into a hex digit with legal/blank/illegal status. A frame
// pulse marks the point where every digit has been captured at least once.
module ssegment_reader #(
   parameter int unsigned STABLE_CNT = 4   // legal 1..255
) (
   input logic              clk,
   input logic              rst_n,
   ssegment_reader_if.slave bus
);

   localparam logic [7:0] STABLE_Q = 8'(STABLE_CNT);
   localparam logic [7:0] PRE_Q    = 8'(STABLE_CNT - 1);

   // last sampled input pair and dwell tracking
   logic [3:0]  grounds_q;
   logic [6:0]  display_q;
   logic [7:0]  dwell_q, dwell_d;

   // registered outputs and frame bookkeeping
   logic [15:0] digits_q, digits_d;
   logic [3:0]  valid_q, valid_d;
   logic [3:0]  err_q, err_d;
   logic        frame_q, frame_d;
   logic [3:0]  seen_q, seen_d;

   // combinational helpers
   logic        sel_valid;
   logic        match;
   logic        capture;
   logic [3:0]  sel_hit;
   logic [3:0]  seg_code;
   logic        seg_legal;
   logic        seg_blank;
   logic [3:0]  seen_nxt;

   // A select is usable only when exactly one digit line is pulled low
   always_comb begin
      sel_valid = 1'b0;
      case (bus.grounds)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: sel_valid = 1'b1;
         default:                            sel_valid = 1'b0;
      endcase
   end

   // Per-digit capture strobe; with a valid select only one bit can be set
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_hit
         assign sel_hit[gi] = capture & ~bus.grounds[gi];
      end
   endgenerate

   // Segment pattern to hex decode; blank is tracked separately from illegal
   always_comb begin
      seg_code  = 4'h0;
      seg_legal = 1'b1;
      case (bus.display)
         7'h7E: seg_code = 4'h0;
         7'h30: seg_code = 4'h1;
         7'h6D: seg_code = 4'h2;
         7'h79: seg_code = 4'h3;
         7'h33: seg_code = 4'h4;
         7'h5B: seg_code = 4'h5;
         7'h5F: seg_code = 4'h6;
         7'h70: seg_code = 4'h7;
         7'h7F: seg_code = 4'h8;
         7'h7B: seg_code = 4'h9;
         7'h77: seg_code = 4'hA;
         7'h1F: seg_code = 4'hB;
         7'h4E: seg_code = 4'hC;
         7'h3D: seg_code = 4'hD;
         7'h4F: seg_code = 4'hE;
         7'h47: seg_code = 4'hF;
         default: seg_legal = 1'b0;
      endcase
      seg_blank = (bus.display == 7'h00);
   end

   // Dwell counting, capture decision and next-state of the outputs
   always_comb begin
      match   = sel_valid && (bus.grounds == grounds_q) && (bus.display == display_q);
      dwell_d = 8'd0;
      if (match) begin
         dwell_d = (dwell_q >= STABLE_Q) ? STABLE_Q : dwell_q + 8'd1;
      end
      // Fires only on the STABLE_CNT-1 -> STABLE_CNT step, so a saturated
      // counter never re-captures the same dwell.
      capture = match && (dwell_q == PRE_Q);

      digits_d = digits_q;
      valid_d  = valid_q;
      err_d    = err_q;
      frame_d  = 1'b0;
      seen_d   = seen_q;
      seen_nxt = seen_q | sel_hit;

      for (int i = 0; i < 4; i++) begin
         if (sel_hit[i]) begin
            if (seg_legal) begin
               digits_d[4*i +: 4] = seg_code;
               valid_d[i]         = 1'b1;
               err_d[i]           = 1'b0;
            end else begin
               // blank and illegal both keep the old value, only err differs
               valid_d[i] = 1'b0;
               err_d[i]   = ~seg_blank;
            end
         end
      end

      if (capture) begin
         if (seen_nxt == 4'hF) begin
            frame_d = 1'b1;
            seen_d  = 4'h0;
         end else begin
            seen_d  = seen_nxt;
         end
      end
   end

   // State registers; reset parks the last pair on an invalid select
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grounds_q <= 4'hF;
         display_q <= 7'h00;
         dwell_q   <= 8'd0;
         digits_q  <= 16'h0000;
         valid_q   <= 4'h0;
         err_q     <= 4'h0;
         frame_q   <= 1'b0;
         seen_q    <= 4'h0;
      end else begin
         grounds_q <= bus.grounds;
         display_q <= bus.display;
         dwell_q   <= dwell_d;
         digits_q  <= digits_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         frame_q   <= frame_d;
         seen_q    <= seen_d;
      end
   end

   assign bus.digits = digits_q;
   assign bus.valid  = valid_q;
   assign bus.err    = err_q;
   assign bus.frame  = frame_q;

endmodule

// File: tb/tb_ssegment_reader.sv
// Directed bench for ssegment_reader with STABLE_CNT = 4: reset behaviour,
// dwell/capture timing, legal/illegal/blank decode, frame pulse, invalid
// selects and a reset pulse in the middle of a dwell.
module tb_ssegment_reader;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   frame_cnt;
   int   frame_base;

   ssegment_reader_if bus();

   ssegment_reader #(.STABLE_CNT(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // count frame pulses, sampled away from the active edge
   always @(negedge clk) begin
      if (rst_n && bus.frame === 1'b1) frame_cnt++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // advance n rising edges, then settle 1ns past the last one
   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input logic [3:0] g, input logic [6:0] d);
      bus.grounds = g;
      bus.display = d;
   endtask

   function automatic logic [31:0] outs();
      return {7'd0, bus.digits, bus.valid, bus.err, bus.frame};
   endfunction

   initial begin
      logic [3:0] gseq [4];
      logic [6:0] dseq [4];
      checks    = 0;
      errors    = 0;
      frame_cnt = 0;
      rst_n     = 1'b0;
      drive(4'hF, 7'h00);

      // reset held low with random inputs
      for (int i = 0; i < 8; i++) begin
         step(1);
         drive(4'($urandom), 7'($urandom));
         check_eq("reset_outs", outs(), 32'h0);
      end
      $display("reset phase done");

      // single digit A on digit 0, held 25 edges
      rst_n = 1'b1;
      drive(4'b1110, 7'h77);
      step(4);
      check_eq("dwell4_valid", {28'd0, bus.valid}, 32'h0);
      check_eq("dwell4_digits", {16'd0, bus.digits}, 32'h0);
      step(1);
      check_eq("cap5_digit0", {28'd0, bus.digits[3:0]}, 32'hA);
      check_eq("cap5_valid", {28'd0, bus.valid}, 32'h1);
      check_eq("cap5_err_frame", {27'd0, bus.err, bus.frame}, 32'h0);
      for (int i = 0; i < 20; i++) begin
         step(1);
         check_eq("hold_stable", outs(), {7'd0, 16'h000A, 4'h1, 4'h0, 1'b0});
      end
      check_eq("hold_no_frame", frame_cnt, 0);
      $display("single digit capture done");

      // scan digits 0..3 with 1,2,3,4
      gseq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      dseq = '{7'h30, 7'h6D, 7'h79, 7'h33};
      frame_base = frame_cnt;
      for (int i = 0; i < 4; i++) begin
         drive(gseq[i], dseq[i]);
         step(5);
         check_eq("scan_field", {28'd0, 4'((bus.digits >> (4*i)) & 16'hF)}, i + 1);
         check_eq("scan_frame_edge", {31'd0, bus.frame}, (i == 3) ? 32'h1 : 32'h0);
         step(3);
         $display("scan digit %0d captured", i);
      end
      check_eq("scan_digits", {16'd0, bus.digits}, 32'h4321);
      check_eq("scan_valid", {28'd0, bus.valid}, 32'hF);
      check_eq("scan_frame_count", frame_cnt - frame_base, 1);

      // digit 2: legal 8, then illegal 01, then blank 00
      drive(4'b1011, 7'h7F);
      step(8);
      check_eq("d2_legal_digits", {16'd0, bus.digits}, 32'h4821);
      drive(4'b1011, 7'h01);
      step(8);
      check_eq("d2_illegal_err", {28'd0, bus.err}, 32'h4);
      check_eq("d2_illegal_valid", {28'd0, bus.valid}, 32'hB);
      check_eq("d2_illegal_keep", {28'd0, bus.digits[11:8]}, 32'h8);
      drive(4'b1011, 7'h00);
      step(8);
      check_eq("d2_blank_err", {28'd0, bus.err}, 32'h0);
      check_eq("d2_blank_valid", {28'd0, bus.valid}, 32'hB);
      check_eq("d2_blank_keep", {16'd0, bus.digits}, 32'h4821);
      $display("illegal/blank sequence done");

      // short dwells and a multi-select never capture
      frame_base = frame_cnt;
      drive(4'b1101, 7'h5B);
      step(4);
      drive(4'b1101, 7'h4F);
      step(4);
      drive(4'b1100, 7'h33);
      step(10);
      check_eq("nocap_outs", outs(), {7'd0, 16'h4821, 4'hB, 4'h0, 1'b0});
      check_eq("nocap_frame", frame_cnt - frame_base, 0);
      $display("no-capture sequence done");

      // reset pulse mid-dwell on digit 3 showing C
      drive(4'b0111, 7'h4E);
      step(3);
      rst_n = 1'b0;
      #1;
      check_eq("async_reset_outs", outs(), 32'h0);
      #1;
      rst_n = 1'b1;
      step(4);
      check_eq("post_rst4_valid", {28'd0, bus.valid}, 32'h0);
      check_eq("post_rst4_digits", {16'd0, bus.digits}, 32'h0);
      step(1);
      check_eq("post_rst5_digits", {16'd0, bus.digits}, 32'hC000);
      check_eq("post_rst5_valid", {28'd0, bus.valid}, 32'h8);
      $display("reset mid-dwell done");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
